// File: rtl/sdram_fsm_pkg.sv
// Shared SDRAM controller definitions: init/work state codes and pin command encodings.
// Used by the master FSM and the command encoder stage.
package sdram_fsm_pkg;

  typedef enum logic [4:0] {
    I_NOP  = 5'd0,
    I_PRE  = 5'd1,
    I_TRP  = 5'd2,
    I_AR   = 5'd3,
    I_TRF  = 5'd4,
    I_MRS  = 5'd5,
    I_TRSC = 5'd6,
    I_DONE = 5'd7
  } init_st_t;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TWR    = 4'd8,
    W_PRE    = 4'd9,
    W_TRP    = 4'd10,
    W_AR     = 4'd11,
    W_TRFC   = 4'd12
  } work_st_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_INIT  = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRGE  = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_BSTOP = 4'b0110;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sdram_fsm_ref_timer.sv
// Refresh interval timer: raises ref_req every REF_PERIOD cycles once init is done.
// With SDRAM_REF_MISS_EN, o_ref_miss latches when a request is still pending at the next wrap.
module sdram_ref_timer
  import sdram_fsm_pkg::*;
#(
  parameter int REF_PERIOD = 782
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_ref_ack,
  output logic o_ref_req
`ifdef SDRAM_REF_MISS_EN
  ,
  output logic o_ref_miss
`endif
);

  localparam int CW = $clog2(REF_PERIOD);
  localparam logic [CW-1:0] L_END = CW'(REF_PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_ref_req;
  logic          w_wrap;

  assign w_wrap    = i_en && (r_cnt == L_END);
  assign o_ref_req = r_ref_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_ref_req <= 1'b0;
    end else begin
      if (!i_en || w_wrap) r_cnt <= '0;
      else                 r_cnt <= r_cnt + CW'(1);
      if (w_wrap)         r_ref_req <= 1'b1;
      else if (i_ref_ack) r_ref_req <= 1'b0;
    end
  end

`ifdef SDRAM_REF_MISS_EN
  logic r_ref_miss;

  assign o_ref_miss = r_ref_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_miss <= 1'b0;
    end else if (w_wrap && r_ref_req && !i_ref_ack) begin
      r_ref_miss <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sdram_fsm.sv
// SDRAM controller master FSM: power-up init, refresh scheduling and burst sequencing.
// Define SDRAM_REF_MISS_EN to add the sticky o_ref_miss overdue-refresh flag.
module sdram_fsm
  import sdram_fsm_pkg::*;
#(
  parameter int T_POWERUP  = 20000,
  parameter int T_RP       = 2,
  parameter int T_RFC      = 7,
  parameter int T_MRD      = 2,
  parameter int T_RCD      = 2,
  parameter int T_CL       = 3,
  parameter int T_WR       = 2,
  parameter int AR_INIT    = 8,
  parameter int REF_PERIOD = 782
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sdram_wr_req,
  input  logic       i_sdram_rd_req,
  input  logic [9:0] i_sdram_wr_burst,
  input  logic [9:0] i_sdram_rd_burst,
  output logic       o_sdram_wr_ack,
  output logic       o_sdram_rd_ack,
  output logic       o_sdram_init_done,
  output logic [4:0] o_init_state,
  output logic [3:0] o_work_state,
  output logic [9:0] o_cnt_clk,
  output logic       o_sdram_rd_wr
`ifdef SDRAM_REF_MISS_EN
  ,
  output logic       o_ref_miss
`endif
);

  localparam logic [14:0] L_PWR = 15'(T_POWERUP - 1);
  localparam logic [9:0]  L_RP  = 10'(T_RP - 1);
  localparam logic [9:0]  L_RFC = 10'(T_RFC - 1);
  localparam logic [9:0]  L_MRD = 10'(T_MRD - 1);
  localparam logic [9:0]  L_RCD = 10'(T_RCD - 1);
  localparam logic [9:0]  L_CL  = 10'(T_CL - 2);
  localparam logic [9:0]  L_WR  = 10'(T_WR - 1);
  localparam logic [3:0]  L_AR  = 4'(AR_INIT);

  init_st_t    r_init;
  init_st_t    w_init_nxt;
  work_st_t    r_work;
  work_st_t    w_work_nxt;
  logic [9:0]  r_cnt;
  logic [14:0] r_pwr;
  logic [3:0]  r_ar;
  logic        r_rd_wr;
  logic        w_rd_wr_nxt;
  logic        w_done;
  logic        w_chg;
  logic        w_ref_req;
  logic        w_ref_ack;
  logic [9:0]  w_wr_last;
  logic [9:0]  w_rd_last;

  assign w_done    = (r_init == I_DONE);
  assign w_chg     = (w_init_nxt != r_init) || (w_work_nxt != r_work);
  assign w_ref_ack = (r_work == W_IDLE) && (w_work_nxt == W_AR);
  assign w_wr_last = i_sdram_wr_burst - 10'd1;
  assign w_rd_last = i_sdram_rd_burst - 10'd1;

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_ref_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_done),
    .i_ref_ack  (w_ref_ack),
    .o_ref_req  (w_ref_req)
`ifdef SDRAM_REF_MISS_EN
    ,
    .o_ref_miss (o_ref_miss)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init  <= I_NOP;
      r_work  <= W_IDLE;
      r_cnt   <= '0;
      r_pwr   <= '0;
      r_ar    <= '0;
      r_rd_wr <= 1'b1;
    end else begin
      r_init  <= w_init_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_chg ? 10'd0 : sat_inc(r_cnt);
      r_rd_wr <= w_rd_wr_nxt;
      if (r_init == I_NOP) r_pwr <= r_pwr + 15'd1;
      if (r_init == I_AR)  r_ar  <= r_ar + 4'd1;
    end
  end

  always_comb begin
    w_init_nxt  = r_init;
    w_work_nxt  = r_work;
    w_rd_wr_nxt = r_rd_wr;
    unique case (r_init)
      I_NOP:   if (r_pwr == L_PWR) w_init_nxt = I_PRE;
      I_PRE:   w_init_nxt = I_TRP;
      I_TRP:   if (r_cnt == L_RP) w_init_nxt = I_AR;
      I_AR:    w_init_nxt = I_TRF;
      I_TRF:   if (r_cnt == L_RFC)
                 w_init_nxt = (r_ar == L_AR) ? I_MRS : I_AR;
      I_MRS:   w_init_nxt = I_TRSC;
      I_TRSC:  if (r_cnt == L_MRD) w_init_nxt = I_DONE;
      I_DONE:  w_init_nxt = I_DONE;
      default: w_init_nxt = I_NOP;
    endcase
    // Refresh wins at idle; a running burst is never cut short.
    if (!w_done) begin
      w_work_nxt = W_IDLE;
    end else begin
      unique case (r_work)
        W_IDLE: begin
          if (w_ref_req) begin
            w_work_nxt = W_AR;
          end else if (i_sdram_wr_req) begin
            w_work_nxt  = W_ACTIVE;
            w_rd_wr_nxt = 1'b0;
          end else if (i_sdram_rd_req) begin
            w_work_nxt  = W_ACTIVE;
            w_rd_wr_nxt = 1'b1;
          end
        end
        W_ACTIVE: w_work_nxt = W_TRCD;
        W_TRCD:   if (r_cnt == L_RCD)
                    w_work_nxt = r_rd_wr ? W_READ : W_WRITE;
        W_WRITE:  w_work_nxt = W_WD;
        W_WD:     if (r_cnt == w_wr_last) w_work_nxt = W_TWR;
        W_TWR:    if (r_cnt == L_WR) w_work_nxt = W_PRE;
        W_READ:   w_work_nxt = W_CL;
        W_CL:     if (r_cnt == L_CL) w_work_nxt = W_RD;
        W_RD:     if (r_cnt == w_rd_last) w_work_nxt = W_PRE;
        W_PRE:    w_work_nxt = W_TRP;
        W_TRP:    if (r_cnt == L_RP) w_work_nxt = W_IDLE;
        W_AR:     w_work_nxt = W_TRFC;
        W_TRFC:   if (r_cnt == L_RFC) w_work_nxt = W_IDLE;
        default:  w_work_nxt = W_IDLE;
      endcase
    end
  end

  always_comb begin
    o_sdram_wr_ack = 1'b0;
    o_sdram_rd_ack = 1'b0;
    unique case (1'b1)
      (r_work == W_WRITE): o_sdram_wr_ack = 1'b1;
      (r_work == W_WD):    o_sdram_wr_ack = (r_cnt < w_wr_last);
      (r_work == W_RD):    o_sdram_rd_ack = 1'b1;
      default: ;
    endcase
  end

  assign o_sdram_init_done = w_done;
  assign o_init_state      = r_init;
  assign o_work_state      = r_work;
  assign o_cnt_clk         = r_cnt;
  assign o_sdram_rd_wr     = r_rd_wr;

endmodule

// File: tb/tb_sdram_fsm.sv
// Directed bench for sdram_fsm: init timing, write/read bursts, refresh ordering, reset abort.
// Builds with or without SDRAM_REF_MISS_EN.
module tb_sdram_fsm;
  import sdram_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req, rd_req;
  logic [9:0] wr_burst, rd_burst;
  logic       wr_ack, rd_ack, init_done, rd_wr;
  logic [4:0] init_state;
  logic [3:0] work_state;
  logic [9:0] cnt_clk;
`ifdef SDRAM_REF_MISS_EN
  logic       ref_miss;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int p0 = 0;
  int n_wr, n_rd, n_rd_bad;
  logic [3:0] trace[$];
  logic [3:0] expq[$];

  sdram_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_sdram_wr_req    (wr_req),
    .i_sdram_rd_req    (rd_req),
    .i_sdram_wr_burst  (wr_burst),
    .i_sdram_rd_burst  (rd_burst),
    .o_sdram_wr_ack    (wr_ack),
    .o_sdram_rd_ack    (rd_ack),
    .o_sdram_init_done (init_done),
    .o_init_state      (init_state),
    .o_work_state      (work_state),
    .o_cnt_clk         (cnt_clk),
    .o_sdram_rd_wr     (rd_wr)
`ifdef SDRAM_REF_MISS_EN
    ,
    .o_ref_miss        (ref_miss)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_obs();
    trace.delete();
    expq.delete();
    n_wr = 0;
    n_rd = 0;
    n_rd_bad = 0;
  endtask

  task automatic add(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) expq.push_back(s);
  endtask

  task automatic tick();
    @(negedge clk);
    if (wr_ack) begin
      n_wr++;
      wr_req = 1'b0;
    end
    if (rd_ack) begin
      n_rd++;
      if (work_state != W_RD) n_rd_bad++;
      rd_req = 1'b0;
    end
    trace.push_back(work_state);
  endtask

  task automatic run_to_idle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (work_state == W_IDLE) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, ok, 1);
  endtask

  task automatic cmp_trace(input string tag);
    int bad;
    int n;
    bad = 0;
    n = (trace.size() < expq.size()) ? trace.size() : expq.size();
    chk({tag, "_len"}, trace.size(), expq.size());
    for (int i = 0; i < n; i++) if (trace[i] !== expq[i]) bad++;
    chk({tag, "_seq"}, bad, 0);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 4000 && cyc < target; i++) @(negedge clk);
  endtask

  task automatic run_init(input string tag);
    int n, ars;
    bit seen;
    logic [4:0] prev;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    ars = 0;
    seen = 1'b0;
    prev = I_NOP;
    for (int i = 0; i < 25000; i++) begin
      @(negedge clk);
      n++;
      if (init_state == I_AR && prev != I_AR) ars++;
      prev = init_state;
      if (init_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, seen, 1);
    chk({tag, "_time"}, (n >= 20069 && n <= 20071), 1);
    chk({tag, "_ar_visits"}, ars, 8);
    chk({tag, "_cnt0"}, cnt_clk, 0);
    chk({tag, "_work"}, work_state, W_IDLE);
    p0 = cyc;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_init"}, init_state, I_NOP);
    chk({tag, "_work"}, work_state, W_IDLE);
    chk({tag, "_cnt"}, cnt_clk, 0);
    chk({tag, "_rdwr"}, rd_wr, 1);
    chk({tag, "_wack"}, wr_ack, 0);
    chk({tag, "_rack"}, rd_ack, 0);
    chk({tag, "_done"}, init_done, 0);
`ifdef SDRAM_REF_MISS_EN
    chk({tag, "_miss"}, ref_miss, 0);
`endif
  endtask

  initial begin
    int i_ar, i_wr, i_rd;
    bit found;
    rst_n = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    wr_burst = 10'd8;
    rd_burst = 10'd16;
    clr_obs();
    repeat (3) @(negedge clk);
    chk_reset("rst");

    run_init("init1");
    @(negedge clk);
    chk("done_cnt1", cnt_clk, 1);

    // write burst of 8
    clr_obs();
    wr_burst = 10'd8;
    wr_req = 1'b1;
    run_to_idle("wr8", 40);
    add(W_ACTIVE, 1); add(W_TRCD, 2); add(W_WRITE, 1); add(W_WD, 8);
    add(W_TWR, 2); add(W_PRE, 1); add(W_TRP, 2); add(W_IDLE, 1);
    cmp_trace("wr8");
    chk("wr8_acks", n_wr, 8);
    chk("wr8_rdwr", rd_wr, 0);

    // single-word write
    clr_obs();
    wr_burst = 10'd1;
    wr_req = 1'b1;
    run_to_idle("wr1", 30);
    add(W_ACTIVE, 1); add(W_TRCD, 2); add(W_WRITE, 1); add(W_WD, 1);
    add(W_TWR, 2); add(W_PRE, 1); add(W_TRP, 2); add(W_IDLE, 1);
    cmp_trace("wr1");
    chk("wr1_acks", n_wr, 1);

    // read burst of 16
    clr_obs();
    rd_burst = 10'd16;
    rd_req = 1'b1;
    run_to_idle("rd16", 60);
    add(W_ACTIVE, 1); add(W_TRCD, 2); add(W_READ, 1); add(W_CL, 2);
    add(W_RD, 16); add(W_PRE, 1); add(W_TRP, 2); add(W_IDLE, 1);
    cmp_trace("rd16");
    chk("rd16_acks", n_rd, 16);
    chk("rd16_outside", n_rd_bad, 0);
    chk("rd16_rdwr", rd_wr, 1);

    // 512-word read straddling the first refresh due point
    chk("t5_early", (cyc <= p0 + 772), 1);
    wait_cyc(p0 + 772);
    chk("t5_idle", work_state, W_IDLE);
    clr_obs();
    rd_burst = 10'd512;
    rd_req = 1'b1;
    run_to_idle("rd512", 700);
    add(W_ACTIVE, 1); add(W_TRCD, 2); add(W_READ, 1); add(W_CL, 2);
    add(W_RD, 512); add(W_PRE, 1); add(W_TRP, 2); add(W_IDLE, 1);
    cmp_trace("rd512");
    chk("rd512_acks", n_rd, 512);
    chk("rd512_outside", n_rd_bad, 0);
    clr_obs();
    run_to_idle("ref1", 20);
    add(W_AR, 1); add(W_TRFC, 7); add(W_IDLE, 1);
    cmp_trace("ref1");

    // refresh pending while both requests arrive together
    chk("t4_early", (cyc <= p0 + 1550), 1);
    wait_cyc(p0 + 1550);
    wr_burst = 10'd32;
    wr_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (work_state == W_TWR) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_twr", found, 1);
    clr_obs();
    wr_burst = 10'd4;
    rd_burst = 10'd4;
    wr_req = 1'b1;
    rd_req = 1'b1;
    repeat (42) tick();
    add(W_TWR, 1); add(W_PRE, 1); add(W_TRP, 2); add(W_IDLE, 1);
    add(W_AR, 1); add(W_TRFC, 7); add(W_IDLE, 1);
    add(W_ACTIVE, 1); add(W_TRCD, 2); add(W_WRITE, 1); add(W_WD, 4);
    add(W_TWR, 2); add(W_PRE, 1); add(W_TRP, 2); add(W_IDLE, 1);
    add(W_ACTIVE, 1); add(W_TRCD, 2); add(W_READ, 1); add(W_CL, 2);
    add(W_RD, 4); add(W_PRE, 1); add(W_TRP, 2); add(W_IDLE, 1);
    cmp_trace("t4");
    i_ar = -1;
    i_wr = -1;
    i_rd = -1;
    foreach (trace[k]) begin
      if (trace[k] == W_AR && i_ar < 0) i_ar = k;
      if (trace[k] == W_WRITE && i_wr < 0) i_wr = k;
      if (trace[k] == W_READ && i_rd < 0) i_rd = k;
    end
    chk("t4_order", (i_ar >= 0 && i_ar < i_wr && i_wr < i_rd), 1);
    chk("t4_wacks", n_wr, 4);
    chk("t4_racks", n_rd, 4);
`ifdef SDRAM_REF_MISS_EN
    chk("t4_miss", ref_miss, 0);
`endif

    // reset asserted in the middle of a write burst
    clr_obs();
    wr_burst = 10'd16;
    wr_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (work_state == W_WD) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_wd", found, 1);
    repeat (3) tick();
    chk("t6_wack_pre", wr_ack, 1);
    rst_n = 1'b0;
    wr_req = 1'b0;
    #1;
    chk_reset("t6");
    repeat (2) @(negedge clk);
    run_init("init2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
